pid_mult_arbiter: RTL and testbench
===================================

# pid_mult_arbiter

Shared, pipelined signed multiplier for the three rate-loop PID channels (yaw, roll, pitch) in the body-frame controller. It replaces three per-channel multipliers with one, arbitrating requests round-robin and returning a tagged, shifted and saturated product. It sits between the PID instances and the single DSP multiplier, and all three channels must complete their gain terms within one body-frame control cycle.

## Interface
Parameters:
- WIDTH, 16: operand and result width, signed two's complement.
- SHIFT_W, 4: width of each per-channel right-shift field.

Ports:
- us_clk  input  1  1 MHz system clock.
- resetn  input  1  asynchronous, active-low reset.
- req  input  3  request per channel: bit 0 yaw, bit 1 roll, bit 2 pitch.
- a_in  input  3*WIDTH  operand A per channel; channel i occupies [i*WIDTH +: WIDTH].
- b_in  input  3*WIDTH  operand B per channel, packed as a_in.
- shift_in  input  3*SHIFT_W  right-shift amount per channel.
- gnt  output  3  one-cycle grant pulse, one-hot or zero.
- result_valid  output  3  one-cycle result strobe, one-hot or zero.
- result  output  WIDTH  shared result bus; meaningful only while result_valid != 0.
- busy  output  1  high while any pipeline stage holds a valid operation.
- sat_flag  output  3  sticky per-channel saturation flag (see Configuration).

## Operation
- Requester protocol: raise req[i] with operands stable, and hold req and operands until gnt[i] is seen high. Drop req[i] in the gnt cycle, or at the edge that ends it. A req[i] still high in the cycle after gnt[i] is a new request.
- Arbiter: round-robin over the channels whose req bit is high.
  - Masking: the channel whose gnt is currently high is excluded.
  - Search order starts at last_grant+1, mod 3.
  - last_grant resets to 2, so yaw wins first after reset.
  - At most one issue per clock.
- Pipeline, fixed 3 stages:
  - S0 (issue edge): capture the selected channel's a, b, shift and tag; assert gnt[tag] for the following cycle.
  - S1: full-precision signed product, 2*WIDTH bits.
  - S2: arithmetic right shift by shift (floor toward −inf), then saturate to [−2^(WIDTH−1), 2^(WIDTH−1)−1]; register result and result_valid[tag].
- Back-to-back issue is supported, with one op per stage per cycle.
- busy = OR of the S0/S1/S2 valid bits.
- Outputs are registered, and no output depends combinationally on req.

## Timing
- Reset values: gnt=0, result_valid=0, result=0, busy=0, sat_flag=0, last_grant=2, all stage valids 0.
- Latency:
  - Req high before edge E0 gives gnt high in cycle E0–E1.
  - result_valid is high in cycle E2–E3 (3 edges from issue to visible result).
- result holds its last value while result_valid=0.
- Simultaneous requests are granted on consecutive edges, and results arrive on consecutive cycles in grant order.
- Reset asserted mid-operation: all in-flight operations are discarded immediately (async) and no result_valid is produced for them. Requesters must re-request.
- A new req[i] while channel i already has an op in flight is legal; results return in issue order.

## Configuration
- PID_MULT_SAT_EN defined:
  - S2 saturates out-of-range results.
  - sat_flag[tag] sets on any clamp and clears only on reset.
- Undefined:
  - S2 truncates to the low WIDTH bits of the shifted product (wrap-around).
  - sat_flag is tied to 0.

## Test plan
- Single yaw: a=0x0010, b=0x0003, shift=4 → gnt=3'b001 one cycle later; result_valid=3'b001 two cycles after that; result=0x0003.
- All three requesters held high together from reset → gnt sequence 001, 010, 100 on consecutive cycles; three consecutive result_valid strobes with matching tags and results.
- Fairness: yaw and pitch re-request continuously → grants alternate yaw, pitch, yaw, pitch; roll is never granted.
- Saturation with PID_MULT_SAT_EN:
  - a=0x7FFF, b=0x0004, shift=0 → result 0x7FFF, sat_flag[tag]=1.
  - a=0x8000, b=0x0002 → result 0x8000.
  - Without the macro, the same inputs give 0xFFFC and 0x0000 respectively.
- Negative shift rounding: a=0xFFFD (−3), b=0x0001, shift=1 → result 0xFFFE (−2).
- Reset pulse while two ops are in flight → no result_valid afterwards, busy=0, next single roll request is granted normally.

Source files
------------

// File: rtl/pid_mult_arbiter.sv
// pid_mult_arbiter: round-robin shared 3-stage signed multiply/shift for yaw, roll, pitch.
// Define PID_MULT_SAT_EN to saturate results and enable sat_flag; otherwise results wrap.
module pid_mult_arbiter #(
   parameter int WIDTH   = 16,
   parameter int SHIFT_W = 4
) (
   input  logic                 us_clk,
   input  logic                 resetn,
   input  logic [2:0]           req,
   input  logic [3*WIDTH-1:0]   a_in,
   input  logic [3*WIDTH-1:0]   b_in,
   input  logic [3*SHIFT_W-1:0] shift_in,
   output logic [2:0]           gnt,
   output logic [2:0]           result_valid,
   output logic [WIDTH-1:0]     result,
   output logic                 busy,
   output logic [2:0]           sat_flag
);
   logic [2:0] req_m;
   logic [1:0] last_grant, c1, c2, pick;
   logic issue, s0_v, s1_v;
   logic [1:0] s0_tag, s1_tag;
   logic signed [WIDTH-1:0] s0_a, s0_b;
   logic [SHIFT_W-1:0] s0_sh, s1_sh;
   logic signed [2*WIDTH-1:0] s1_p;
   logic [WIDTH-1:0] s2_res;
   logic ovf;

   // The channel currently holding gnt may still have req high; it must not be reissued.
   always_comb begin
      req_m = req & ~gnt;
      c1    = (last_grant == 2'd2) ? 2'd0 : last_grant + 2'd1;
      c2    = (c1 == 2'd2) ? 2'd0 : c1 + 2'd1;
      pick  = req_m[c1] ? c1 : req_m[c2] ? c2 : last_grant;
      issue = |req_m;
   end

`ifdef PID_MULT_SAT_EN
   logic signed [2*WIDTH-1:0] shifted;
   always_comb begin
      shifted = s1_p >>> s1_sh;
      ovf     = ~(&shifted[2*WIDTH-1:WIDTH-1] | ~|shifted[2*WIDTH-1:WIDTH-1]);
      s2_res  = ovf ? {shifted[2*WIDTH-1], {(WIDTH-1){~shifted[2*WIDTH-1]}}} : shifted[WIDTH-1:0];
   end

   always_ff @(posedge us_clk or negedge resetn)
      if (!resetn)
         sat_flag <= '0;
      else if (s1_v && ovf)
         sat_flag <= sat_flag | (3'b001 << s1_tag);
`else
   always_comb begin
      ovf    = 1'b0;
      s2_res = WIDTH'(s1_p >>> s1_sh);
   end

   assign sat_flag = '0;
`endif

   always_ff @(posedge us_clk or negedge resetn)
      if (!resetn) begin
         last_grant   <= 2'd2;
         gnt          <= '0;
         s0_v         <= 1'b0;
         s0_tag       <= '0;
         s0_a         <= '0;
         s0_b         <= '0;
         s0_sh        <= '0;
         s1_v         <= 1'b0;
         s1_tag       <= '0;
         s1_p         <= '0;
         s1_sh        <= '0;
         result_valid <= '0;
         result       <= '0;
      end else begin
         gnt  <= issue ? (3'b001 << pick) : 3'b000;
         s0_v <= issue;
         if (issue) begin
            last_grant <= pick;
            s0_tag     <= pick;
            s0_a       <= a_in[pick*WIDTH +: WIDTH];
            s0_b       <= b_in[pick*WIDTH +: WIDTH];
            s0_sh      <= shift_in[pick*SHIFT_W +: SHIFT_W];
         end
         s1_v         <= s0_v;
         s1_tag       <= s0_tag;
         s1_p         <= s0_a * s0_b;
         s1_sh        <= s0_sh;
         result_valid <= s1_v ? (3'b001 << s1_tag) : 3'b000;
         if (s1_v)
            result <= s2_res;
      end

   assign busy = s0_v | s1_v | (|result_valid);
endmodule

// File: tb/tb_pid_mult_arbiter.sv
// tb_pid_mult_arbiter: randomized and directed checks of pid_mult_arbiter against a floor/saturate model.
module tb_pid_mult_arbiter;
   logic us_clk = 1'b0;
   logic resetn = 1'b0;
   logic [2:0] req = '0;
   logic [47:0] a_in, b_in;
   logic [11:0] shift_in;
   logic [2:0] gnt, result_valid, sat_flag;
   logic [15:0] result;
   logic busy;
   logic [15:0] op_a[3], op_b[3];
   logic [3:0] op_s[3];
   logic [2:0] gq[$];
   logic [18:0] oq[$];
   int errors = 0, checks = 0;

   assign a_in     = {op_a[2], op_a[1], op_a[0]};
   assign b_in     = {op_b[2], op_b[1], op_b[0]};
   assign shift_in = {op_s[2], op_s[1], op_s[0]};

   pid_mult_arbiter dut (
      .us_clk(us_clk), .resetn(resetn), .req(req), .a_in(a_in), .b_in(b_in),
      .shift_in(shift_in), .gnt(gnt), .result_valid(result_valid), .result(result),
      .busy(busy), .sat_flag(sat_flag)
   );

   always #5 us_clk = ~us_clk;

   always @(negedge us_clk) begin
      if (gnt != 0) gq.push_back(gnt);
      if (result_valid != 0) oq.push_back({result_valid, result});
   end

   initial begin
      #2000000;
      $display("FAIL timeout");
      $fatal(1);
   end

   // Reference: floor(a*b / 2^s), then clamp or keep the low 16 bits.
   function automatic logic [15:0] exp_res(input logic [15:0] a, input logic [15:0] b, input logic [3:0] s);
      longint p, d, q;
      p = longint'($signed(a)) * longint'($signed(b));
      d = longint'(1) << s;
      q = (p >= 0) ? p / d : -((-p + d - 1) / d);
`ifdef PID_MULT_SAT_EN
      if (q > 32767) q = 32767;
      if (q < -32768) q = -32768;
`endif
      return q[15:0];
   endfunction

   task automatic apply_reset();
      resetn = 1'b0;
      req = '0;
      @(negedge us_clk);
      resetn = 1'b1;
      gq.delete();
      oq.delete();
   endtask

   task automatic issue_one(input int ch, input logic [15:0] a, input logic [15:0] b,
                            input logic [3:0] s, output logic [15:0] r, output logic ok);
      op_a[ch] = a;
      op_b[ch] = b;
      op_s[ch] = s;
      req[ch] = 1'b1;
      ok = 1'b0;
      r = '0;
      for (int i = 0; i < 10 && !ok; i++) begin
         @(negedge us_clk);
         if (gnt[ch]) ok = 1'b1;
      end
      req[ch] = 1'b0;
      if (ok) begin
         ok = 1'b0;
         for (int i = 0; i < 10 && !ok; i++) begin
            @(negedge us_clk);
            if (result_valid[ch]) begin
               ok = 1'b1;
               r = result;
            end
         end
      end
   endtask

   task automatic test_reset();
      for (int i = 0; i < 3; i++) begin
         op_a[i] = '0;
         op_b[i] = '0;
         op_s[i] = '0;
      end
      @(negedge us_clk);
      checks++; if (gnt !== 3'b000) begin errors++; $display("FAIL reset_gnt got %b want 000", gnt); end
      checks++; if (result_valid !== 3'b000) begin errors++; $display("FAIL reset_rv got %b want 000", result_valid); end
      checks++; if (result !== 16'h0000) begin errors++; $display("FAIL reset_result got %h want 0000", result); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
      checks++; if (sat_flag !== 3'b000) begin errors++; $display("FAIL reset_sat got %b want 000", sat_flag); end
      resetn = 1'b1;
   endtask

   task automatic test_single_yaw();
      op_a[0] = 16'h0010;
      op_b[0] = 16'h0003;
      op_s[0] = 4'd4;
      req = 3'b001;
      @(negedge us_clk);
      checks++; if (gnt !== 3'b001) begin errors++; $display("FAIL single_gnt got %b want 001", gnt); end
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy got %b want 1", busy); end
      req = 3'b000;
      @(negedge us_clk);
      checks++; if (gnt !== 3'b000 || result_valid !== 3'b000) begin errors++; $display("FAIL single_mid got gnt=%b rv=%b want 000/000", gnt, result_valid); end
      @(negedge us_clk);
      checks++; if (result_valid !== 3'b001) begin errors++; $display("FAIL single_rv got %b want 001", result_valid); end
      checks++; if (result !== 16'h0003) begin errors++; $display("FAIL single_result got %h want 0003", result); end
      @(negedge us_clk);
      checks++; if (result_valid !== 3'b000 || result !== 16'h0003) begin errors++; $display("FAIL single_hold got rv=%b res=%h want 000/0003", result_valid, result); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_idle got %b want 0", busy); end
   endtask

   task automatic test_all_three();
      apply_reset();
      for (int i = 0; i < 3; i++) begin
         op_a[i] = 16'($urandom);
         op_b[i] = 16'($urandom);
         op_s[i] = 4'($urandom);
      end
      req = 3'b111;
      for (int i = 0; i < 3; i++) begin
         @(negedge us_clk);
         checks++; if (gnt !== (3'b001 << i)) begin errors++; $display("FAIL all3_gnt%0d got %b want %b", i, gnt, 3'b001 << i); end
         req = req & ~gnt;
      end
      req = 3'b000;
      repeat (4) @(negedge us_clk);
      checks++; if (oq.size() != 3) begin errors++; $display("FAIL all3_count got %0d want 3", oq.size()); end
      for (int i = 0; i < 3 && i < oq.size(); i++) begin
         checks++;
         if (oq[i] !== {3'b001 << i, exp_res(op_a[i], op_b[i], op_s[i])}) begin
            errors++; $display("FAIL all3_res%0d got %h want %h", i, oq[i], {3'b001 << i, exp_res(op_a[i], op_b[i], op_s[i])});
         end
      end
   endtask

   task automatic test_fairness();
      apply_reset();
      req = 3'b101;
      repeat (8) @(negedge us_clk);
      req = 3'b000;
      repeat (4) @(negedge us_clk);
      checks++; if (gq.size() < 8) begin errors++; $display("FAIL fair_count got %0d want >=8", gq.size()); end
      for (int i = 0; i < 8 && i < gq.size(); i++) begin
         checks++;
         if (gq[i] !== ((i % 2 == 0) ? 3'b001 : 3'b100)) begin
            errors++; $display("FAIL fair_gnt%0d got %b want %b", i, gq[i], (i % 2 == 0) ? 3'b001 : 3'b100);
         end
      end
   endtask

   task automatic test_saturation();
      logic [15:0] r;
      logic ok;
      apply_reset();
      issue_one(0, 16'h7FFF, 16'h0004, 4'd0, r, ok);
      checks++; if (!ok) begin errors++; $display("FAIL sat_pos_handshake got timeout want result"); end
`ifdef PID_MULT_SAT_EN
      checks++; if (r !== 16'h7FFF) begin errors++; $display("FAIL sat_pos got %h want 7fff", r); end
      checks++; if (sat_flag !== 3'b001) begin errors++; $display("FAIL sat_flag_pos got %b want 001", sat_flag); end
`else
      checks++; if (r !== 16'hFFFC) begin errors++; $display("FAIL wrap_pos got %h want fffc", r); end
      checks++; if (sat_flag !== 3'b000) begin errors++; $display("FAIL wrap_flag got %b want 000", sat_flag); end
`endif
      issue_one(1, 16'h8000, 16'h0002, 4'd0, r, ok);
      checks++; if (!ok) begin errors++; $display("FAIL sat_neg_handshake got timeout want result"); end
`ifdef PID_MULT_SAT_EN
      checks++; if (r !== 16'h8000) begin errors++; $display("FAIL sat_neg got %h want 8000", r); end
      checks++; if (sat_flag !== 3'b011) begin errors++; $display("FAIL sat_flag_neg got %b want 011", sat_flag); end
`else
      checks++; if (r !== 16'h0000) begin errors++; $display("FAIL wrap_neg got %h want 0000", r); end
`endif
      issue_one(2, 16'hFFFD, 16'h0001, 4'd1, r, ok);
      checks++; if (!ok || r !== 16'hFFFE) begin errors++; $display("FAIL neg_shift got %h ok=%b want fffe", r, ok); end
   endtask

   task automatic test_reset_midflight();
      logic [15:0] r;
      logic ok;
      apply_reset();
      op_a[0] = 16'h0123; op_b[0] = 16'h0002; op_s[0] = 4'd0;
      op_a[1] = 16'h0456; op_b[1] = 16'h0003; op_s[1] = 4'd0;
      req = 3'b011;
      repeat (2) begin
         @(negedge us_clk);
         req = req & ~gnt;
      end
      req = 3'b000;
      #2 resetn = 1'b0;
      #1;
      checks++; if (busy !== 1'b0 || gnt !== 3'b000) begin errors++; $display("FAIL midrst_async got busy=%b gnt=%b want 0/000", busy, gnt); end
      #1 resetn = 1'b1;
      oq.delete();
      repeat (5) @(negedge us_clk);
      checks++; if (oq.size() != 0) begin errors++; $display("FAIL midrst_rv got %0d strobes want 0", oq.size()); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got %b want 0", busy); end
      op_a[1] = 16'h0005; op_b[1] = 16'h0007; op_s[1] = 4'd0;
      req = 3'b010;
      @(negedge us_clk);
      checks++; if (gnt !== 3'b010) begin errors++; $display("FAIL midrst_gnt got %b want 010", gnt); end
      req = 3'b000;
      repeat (2) @(negedge us_clk);
      checks++; if (result_valid !== 3'b010 || result !== 16'd35) begin errors++; $display("FAIL midrst_res got rv=%b res=%h want 010/0023", result_valid, result); end
      @(negedge us_clk);
      issue_one(1, 16'h0004, 16'h0004, 4'd2, r, ok);
      checks++; if (!ok || r !== 16'h0004) begin errors++; $display("FAIL midrst_next got %h ok=%b want 0004", r, ok); end
   endtask

   task automatic test_random();
      int lg, pend, order[$];
      logic [15:0] exp_r;
      apply_reset();
      lg = 2;
      for (int it = 0; it < 40; it++) begin
         pend = int'($urandom_range(1, 7));
         for (int i = 0; i < 3; i++) begin
            op_a[i] = 16'($urandom);
            op_b[i] = 16'($urandom);
            op_s[i] = 4'($urandom);
         end
         order.delete();
         while (pend != 0)
            for (int k = 1; k <= 3; k++)
               if (pend[(lg + k) % 3]) begin
                  lg = (lg + k) % 3;
                  order.push_back(lg);
                  pend[lg] = 1'b0;
                  break;
               end
         gq.delete();
         oq.delete();
         for (int i = 0; i < order.size(); i++) req[order[i]] = 1'b1;
         for (int i = 0; i < 8 && req != 0; i++) begin
            @(negedge us_clk);
            req = req & ~gnt;
         end
         req = 3'b000;
         repeat (4) @(negedge us_clk);
         checks++; if (gq.size() != order.size() || oq.size() != order.size()) begin
            errors++; $display("FAIL rand%0d_count got g=%0d r=%0d want %0d", it, gq.size(), oq.size(), order.size());
         end
         for (int i = 0; i < order.size(); i++) begin
            exp_r = exp_res(op_a[order[i]], op_b[order[i]], op_s[order[i]]);
            if (i < gq.size()) begin
               checks++; if (gq[i] !== (3'b001 << order[i])) begin errors++; $display("FAIL rand%0d_gnt%0d got %b want %b", it, i, gq[i], 3'b001 << order[i]); end
            end
            if (i < oq.size()) begin
               checks++; if (oq[i] !== {3'b001 << order[i], exp_r}) begin errors++; $display("FAIL rand%0d_res%0d got %h want %h", it, i, oq[i], {3'b001 << order[i], exp_r}); end
            end
         end
         checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rand%0d_busy got %b want 0", it, busy); end
      end
   endtask

   initial begin
      test_reset();
      test_single_yaw();
      test_all_three();
      test_fairness();
      test_saturation();
      test_reset_midflight();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
